can_rx_ahb: RTL and testbench

CAN_RX_AHB -- requirements
Module: can_rx_ahb

---
 rtl/can_rx_ahb_if.sv | 31 +++
 rtl/can_rx_ahb.sv | 243 ++++++++++++++++++++++++
 tb/tb_can_rx_ahb.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_rx_ahb_if.sv
// rtl/can_rx_ahb_if.sv - AHB-Lite slave bus bundle for the CAN receive buffer
//
// Purpose: groups the AHB transfer signals so the bus can be passed as one port.
// Signals:
//   HSEL, HADDR[31:0], HWRITE, HTRANS[1:0], HSIZE[2:0], HBURST[2:0], HWDATA[31:0]
//       driven by the master
//   HREADY, HRESP[1:0], HRDATA[31:0]
//       driven by the slave
// Modports: master (bus initiator), slave (can_rx_ahb).
interface can_rx_ahb_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/can_rx_ahb.sv
// rtl/can_rx_ahb.sv - CAN receive frame FIFO with AHB-Lite register access
//
// Purpose: captures frames pulsed by a CAN receiver, queues them in a FIFO of
// FIFO_DEPTH frames and exposes the head frame, status and control over AHB.
// Optional macro: CAN_RX_FILTER_EN adds FILT_ID (FF38) / FILT_MASK (FF3C)
// acceptance filtering; without it every frame is accepted.
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   bus (slave modport)   AHB-Lite slave, zero wait states, always OKAY
//   rxValid               one-cycle pulse: frame fields below are valid
//   rxData, rxDatalen, rxFormat, rxFrameType, rxId   frame fields
//   rxErr                 one-cycle pulse: receive error (sticky)
//   rxIrq                 level interrupt = irqEn & !empty
module can_rx_ahb #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  can_rx_ahb_if.slave bus,
  input  logic        rxValid,
  input  logic [63:0] rxData,
  input  logic [3:0]  rxDatalen,
  input  logic        rxFormat,
  input  logic [1:0]  rxFrameType,
  input  logic [28:0] rxId,
  input  logic        rxErr,
  output logic        rxIrq
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

  localparam logic [15:0] A_RX_DL   = 16'hFF20;
  localparam logic [15:0] A_RX_DH   = 16'hFF24;
  localparam logic [15:0] A_RX_CMD  = 16'hFF28;
  localparam logic [15:0] A_RX_ID   = 16'hFF2C;
  localparam logic [15:0] A_RX_STAT = 16'hFF30;
  localparam logic [15:0] A_RX_CTRL = 16'hFF34;
`ifdef CAN_RX_FILTER_EN
  localparam logic [15:0] A_FILT_ID = 16'hFF38;
  localparam logic [15:0] A_FILT_MK = 16'hFF3C;
`endif

  typedef enum logic {ST_IDLE, ST_CHECK} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic               ovf_q, ovf_d, err_q, err_d, irq_en_q, irq_en_d;
  logic               dp_valid_q, dp_valid_d, dp_write_q, dp_write_d;
  logic [15:0]        dp_addr_q, dp_addr_d;
  logic [63:0]        hold_data_q, hold_data_d;
  logic [3:0]         hold_len_q, hold_len_d;
  logic               hold_fmt_q, hold_fmt_d;
  logic [1:0]         hold_type_q, hold_type_d;
  logic [28:0]        hold_id_q, hold_id_d;
`ifdef CAN_RX_FILTER_EN
  logic [28:0]        filt_id_q, filt_id_d, filt_mask_q, filt_mask_d;
`endif

  // FIFO storage is deliberately not reset; count/pointers define validity.
  logic [63:0] mem_data_q [FIFO_DEPTH];
  logic [3:0]  mem_len_q  [FIFO_DEPTH];
  logic        mem_fmt_q  [FIFO_DEPTH];
  logic [1:0]  mem_type_q [FIFO_DEPTH];
  logic [28:0] mem_id_q   [FIFO_DEPTH];

  logic        empty, full, ctrl_wr, pop, clr, push, drop_ovf, pass;
  logic [31:0] rd_data;

  logic unused_bus;
`ifdef CAN_RX_FILTER_EN
  assign unused_bus = ^{bus.HADDR[31:16], bus.HTRANS[0], bus.HSIZE, bus.HBURST};
`else
  assign unused_bus = ^{bus.HADDR[31:16], bus.HTRANS[0], bus.HSIZE, bus.HBURST,
                        bus.HWDATA[31:3]};
`endif

  assign empty = (count_q == 5'd0);
  assign full  = (count_q == DEPTH_C);

`ifdef CAN_RX_FILTER_EN
  assign pass = (((hold_id_q ^ filt_id_q) & filt_mask_q) == 29'd0);
`else
  assign pass = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    irq_en_d    = irq_en_q;
    hold_data_d = hold_data_q;
    hold_len_d  = hold_len_q;
    hold_fmt_d  = hold_fmt_q;
    hold_type_d = hold_type_q;
    hold_id_d   = hold_id_q;
`ifdef CAN_RX_FILTER_EN
    filt_id_d   = filt_id_q;
    filt_mask_d = filt_mask_q;
`endif
    push        = 1'b0;
    drop_ovf    = 1'b0;

    // Address phase: only NONSEQ/SEQ transfers (HTRANS[1]=1) are decoded.
    dp_valid_d = bus.HSEL & bus.HTRANS[1];
    dp_write_d = bus.HWRITE & dp_valid_d;
    dp_addr_d  = dp_valid_d ? bus.HADDR[15:0] : 16'h0;

    // Data phase write actions.
    ctrl_wr = dp_valid_q & dp_write_q & (dp_addr_q == A_RX_CTRL);
    pop     = ctrl_wr & bus.HWDATA[0] & ~empty;
    clr     = ctrl_wr & bus.HWDATA[1];
    if (ctrl_wr) irq_en_d = bus.HWDATA[2];
`ifdef CAN_RX_FILTER_EN
    if (dp_valid_q && dp_write_q && dp_addr_q == A_FILT_ID) filt_id_d   = bus.HWDATA[31:3];
    if (dp_valid_q && dp_write_q && dp_addr_q == A_FILT_MK) filt_mask_d = bus.HWDATA[31:3];
`endif

    case (state_q)
      ST_IDLE: begin
        if (rxValid) begin
          hold_data_d = rxData;
          hold_len_d  = rxDatalen;
          hold_fmt_d  = rxFormat;
          hold_type_d = rxFrameType;
          hold_id_d   = rxId;
          state_d     = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        // The FSM cannot take a new frame while deciding on the held one.
        if (rxValid) drop_ovf = 1'b1;
        // A pop in the same cycle frees the slot a full FIFO needs.
        if (pass) begin
          if (!full || pop) push = 1'b1;
          else              drop_ovf = 1'b1;
        end
      end
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase

    // Clear first so a same-cycle set takes priority.
    if (clr) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end
    if (drop_ovf) ovf_d = 1'b1;
    if (rxErr)    err_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 5'd0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_addr_q   <= 16'h0;
      hold_data_q <= 64'h0;
      hold_len_q  <= 4'h0;
      hold_fmt_q  <= 1'b0;
      hold_type_q <= 2'b0;
      hold_id_q   <= 29'h0;
`ifdef CAN_RX_FILTER_EN
      filt_id_q   <= 29'h0;
      filt_mask_q <= 29'h0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_addr_q   <= dp_addr_d;
      hold_data_q <= hold_data_d;
      hold_len_q  <= hold_len_d;
      hold_fmt_q  <= hold_fmt_d;
      hold_type_q <= hold_type_d;
      hold_id_q   <= hold_id_d;
`ifdef CAN_RX_FILTER_EN
      filt_id_q   <= filt_id_d;
      filt_mask_q <= filt_mask_d;
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= hold_data_q;
      mem_len_q[wr_ptr_q]  <= hold_len_q;
      mem_fmt_q[wr_ptr_q]  <= hold_fmt_q;
      mem_type_q[wr_ptr_q] <= hold_type_q;
      mem_id_q[wr_ptr_q]   <= hold_id_q;
    end
  end

  // Read data is driven from the registered address so it lands in the data phase.
  always_comb begin
    rd_data = 32'h0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        A_RX_DL:   if (!empty) rd_data = mem_data_q[rd_ptr_q][31:0];
        A_RX_DH:   if (!empty) rd_data = mem_data_q[rd_ptr_q][63:32];
        A_RX_CMD:  if (!empty) rd_data = {20'h0, mem_len_q[rd_ptr_q], mem_fmt_q[rd_ptr_q],
                                          mem_type_q[rd_ptr_q], 5'h0};
        A_RX_ID:   if (!empty) rd_data = {mem_id_q[rd_ptr_q], 3'h0};
        A_RX_STAT: rd_data = {23'h0, err_q, ovf_q, full, empty, count_q};
        A_RX_CTRL: rd_data = {29'h0, irq_en_q, 2'h0};
`ifdef CAN_RX_FILTER_EN
        A_FILT_ID: rd_data = {filt_id_q, 3'h0};
        A_FILT_MK: rd_data = {filt_mask_q, 3'h0};
`endif
        default:   rd_data = 32'h0;
      endcase
    end
  end

  assign bus.HRDATA = rd_data;
  assign bus.HREADY = 1'b1;
  assign bus.HRESP  = 2'b00;
  assign rxIrq      = irq_en_q & ~empty;

endmodule

// File: tb/tb_can_rx_ahb.sv
// tb/tb_can_rx_ahb.sv - directed self-checking bench for can_rx_ahb
module tb_can_rx_ahb;
  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic [3:0]  rx_len;
  logic        rx_fmt;
  logic [1:0]  rx_type;
  logic [28:0] rx_id;
  logic        rx_err;
  logic        rx_irq;
  int          n_checks;
  int          n_fail;

  can_rx_ahb_if bus ();

  can_rx_ahb #(.FIFO_DEPTH(4)) dut (
    .HCLK(clk), .HRESET(rst), .bus(bus),
    .rxValid(rx_valid), .rxData(rx_data), .rxDatalen(rx_len), .rxFormat(rx_fmt),
    .rxFrameType(rx_type), .rxId(rx_id), .rxErr(rx_err), .rxIrq(rx_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
  endtask

  task automatic ahb_read(input logic [15:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = {16'h0, a};
    @(posedge clk); #1;
    idle_bus();
    d = bus.HRDATA;
  endtask

  task automatic ahb_write(input logic [15:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = {16'h0, a};
    @(posedge clk); #1;
    idle_bus();
    bus.HWDATA = d;
  endtask

  task automatic send_frame(input logic [63:0] d, input logic [3:0] l, input logic [28:0] id);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d; rx_len = l; rx_fmt = 1'b0; rx_type = 2'b00; rx_id = id;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.HRDATA !== 32'h0) begin $display("FAIL reset_hrdata got=%h exp=0", bus.HRDATA); n_fail++; end
    n_checks++; if (rx_irq !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", rx_irq); n_fail++; end
    n_checks++; if ({bus.HREADY, bus.HRESP} !== 3'b100) begin $display("FAIL reset_hready_hresp got=%b exp=100", {bus.HREADY, bus.HRESP}); n_fail++; end
    rst = 1'b0;
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL reset_status got=%h exp=020", d); n_fail++; end
    ahb_read(16'hFF20, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL reset_dl_empty got=%h exp=0", d); n_fail++; end
    ahb_read(16'hFF34, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL reset_ctrl got=%h exp=0", d); n_fail++; end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    // Pipelined STATUS reads: address phases in the rxValid and CHECK cycles.
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 64'h1122334455667788; rx_len = 4'd8; rx_fmt = 1'b0;
    rx_type = 2'b00; rx_id = 29'h123;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = 32'hFF30;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    n_checks++; if (bus.HRDATA !== 32'h020) begin $display("FAIL basic_status_1cyc got=%h exp=020", bus.HRDATA); n_fail++; end
    @(posedge clk); #1;
    idle_bus();
    n_checks++; if (bus.HRDATA !== 32'h001) begin $display("FAIL basic_status_2cyc got=%h exp=001", bus.HRDATA); n_fail++; end
    ahb_read(16'hFF20, d);
    n_checks++; if (d !== 32'h55667788) begin $display("FAIL basic_dl got=%h exp=55667788", d); n_fail++; end
    ahb_read(16'hFF24, d);
    n_checks++; if (d !== 32'h11223344) begin $display("FAIL basic_dh got=%h exp=11223344", d); n_fail++; end
    ahb_read(16'hFF28, d);
    n_checks++; if (d !== 32'h800) begin $display("FAIL basic_cmd got=%h exp=800", d); n_fail++; end
    ahb_read(16'hFF2C, d);
    n_checks++; if (d !== 32'h918) begin $display("FAIL basic_id got=%h exp=918", d); n_fail++; end
    ahb_write(16'hFF34, 32'h1);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL basic_status_popped got=%h exp=020", d); n_fail++; end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 1; i <= 5; i++)
      send_frame({32'hA0000000 + 32'(i), 32'hB0000000 + 32'(i)}, 4'(i), 29'(i));
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h0C4) begin $display("FAIL ovf_status_full got=%h exp=0C4", d); n_fail++; end
    for (int i = 1; i <= 4; i++) begin
      ahb_read(16'hFF20, d);
      n_checks++; if (d !== 32'hB0000000 + 32'(i)) begin $display("FAIL ovf_order_dl%0d got=%h exp=%h", i, d, 32'hB0000000 + 32'(i)); n_fail++; end
      ahb_read(16'hFF28, d);
      n_checks++; if (d !== 32'(i) << 8) begin $display("FAIL ovf_order_cmd%0d got=%h exp=%h", i, d, 32'(i) << 8); n_fail++; end
      ahb_write(16'hFF34, 32'h1);
    end
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h0A0) begin $display("FAIL ovf_status_drained got=%h exp=0A0", d); n_fail++; end
    ahb_write(16'hFF34, 32'h2);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL ovf_clear got=%h exp=020", d); n_fail++; end
  endtask

  task automatic test_pop_push_full();
    logic [31:0] d;
    for (int i = 10; i <= 13; i++) send_frame(64'(i), 4'd1, 29'(i));
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h044) begin $display("FAIL ppf_full got=%h exp=044", d); n_fail++; end
    // rxValid cycle doubles as the write address phase; pop lands in CHECK.
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 64'd14; rx_len = 4'd1; rx_id = 29'd14;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = 32'hFF34;
    @(posedge clk); #1;
    rx_valid = 1'b0; idle_bus(); bus.HWDATA = 32'h1;
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h044) begin $display("FAIL ppf_status got=%h exp=044", d); n_fail++; end
    for (int i = 11; i <= 14; i++) begin
      ahb_read(16'hFF2C, d);
      n_checks++; if (d !== 32'(i) << 3) begin $display("FAIL ppf_id%0d got=%h exp=%h", i, d, 32'(i) << 3); n_fail++; end
      ahb_write(16'hFF34, 32'h1);
    end
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL ppf_drained got=%h exp=020", d); n_fail++; end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    send_frame(64'h77, 4'd2, 29'h7);
    ahb_write(16'hFF34, 32'h4);
    n_checks++; if (rx_irq !== 1'b0) begin $display("FAIL irq_before_en got=%b exp=0", rx_irq); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (rx_irq !== 1'b1) begin $display("FAIL irq_enabled got=%b exp=1", rx_irq); n_fail++; end
    ahb_write(16'hFF34, 32'h5);
    n_checks++; if (rx_irq !== 1'b1) begin $display("FAIL irq_in_pop_dphase got=%b exp=1", rx_irq); n_fail++; end
    @(posedge clk); #1;
    n_checks++; if (rx_irq !== 1'b0) begin $display("FAIL irq_after_pop got=%b exp=0", rx_irq); n_fail++; end
    ahb_read(16'hFF34, d);
    n_checks++; if (d !== 32'h4) begin $display("FAIL irq_ctrl_read got=%h exp=4", d); n_fail++; end
    ahb_write(16'hFF34, 32'h5);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL irq_pop_empty got=%h exp=020", d); n_fail++; end
    n_checks++; if (rx_irq !== 1'b0) begin $display("FAIL irq_empty got=%b exp=0", rx_irq); n_fail++; end
    ahb_write(16'hFF34, 32'h0);
  endtask

  task automatic test_check_overflow();
    logic [31:0] d;
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 64'h55; rx_len = 4'd1; rx_id = 29'h55;
    @(posedge clk); #1;
    rx_id = 29'h66; rx_data = 64'h66;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h081) begin $display("FAIL chk_ovf_status got=%h exp=081", d); n_fail++; end
    ahb_read(16'hFF2C, d);
    n_checks++; if (d !== 32'h2A8) begin $display("FAIL chk_ovf_id got=%h exp=2A8", d); n_fail++; end
    @(posedge clk); #1; rx_err = 1'b1;
    @(posedge clk); #1; rx_err = 1'b0;
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h181) begin $display("FAIL err_sticky got=%h exp=181", d); n_fail++; end
    // Clear stickies while rxErr pulses in the same data phase: error must survive.
    ahb_write(16'hFF34, 32'h2);
    rx_err = 1'b1;
    @(posedge clk); #1; rx_err = 1'b0;
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h101) begin $display("FAIL set_wins got=%h exp=101", d); n_fail++; end
    ahb_write(16'hFF34, 32'h3);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL clear_all got=%h exp=020", d); n_fail++; end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    ahb_write(16'hFF00, 32'hFFFFFFFF);
    ahb_read(16'hFF00, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL unmapped_ff00 got=%h exp=0", d); n_fail++; end
    ahb_read(16'hFF44, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL unmapped_ff44 got=%h exp=0", d); n_fail++; end
`ifndef CAN_RX_FILTER_EN
    ahb_write(16'hFF38, 32'hFFFFFFF8);
    ahb_read(16'hFF38, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL unmapped_ff38 got=%h exp=0", d); n_fail++; end
    // A stray filter write must not drop frames in the default build.
    send_frame(64'h99, 4'd1, 29'h124);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h001) begin $display("FAIL nofilter_pass got=%h exp=001", d); n_fail++; end
    ahb_write(16'hFF34, 32'h1);
`endif
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL unmapped_status got=%h exp=020", d); n_fail++; end
  endtask

`ifdef CAN_RX_FILTER_EN
  task automatic test_filter();
    logic [31:0] d;
    ahb_write(16'hFF38, 32'h918);
    ahb_write(16'hFF3C, 32'hFFFFFFF8);
    ahb_read(16'hFF38, d);
    n_checks++; if (d !== 32'h918) begin $display("FAIL filt_id_rb got=%h exp=918", d); n_fail++; end
    ahb_read(16'hFF3C, d);
    n_checks++; if (d !== 32'hFFFFFFF8) begin $display("FAIL filt_mask_rb got=%h exp=FFFFFFF8", d); n_fail++; end
    send_frame(64'h1, 4'd1, 29'h123);
    send_frame(64'h2, 4'd1, 29'h124);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h001) begin $display("FAIL filt_status got=%h exp=001", d); n_fail++; end
    ahb_read(16'hFF2C, d);
    n_checks++; if (d !== 32'h918) begin $display("FAIL filt_id_head got=%h exp=918", d); n_fail++; end
    ahb_write(16'hFF34, 32'h1);
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL filt_drained got=%h exp=020", d); n_fail++; end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    send_frame(64'hA, 4'd1, 29'hA);
    send_frame(64'hB, 4'd1, 29'hB);
    ahb_write(16'hFF34, 32'h4);
    @(posedge clk); #1;
    n_checks++; if (rx_irq !== 1'b1) begin $display("FAIL rstmid_irq_pre got=%b exp=1", rx_irq); n_fail++; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rx_irq !== 1'b0) begin $display("FAIL rstmid_irq got=%b exp=0", rx_irq); n_fail++; end
    rst = 1'b0;
    ahb_read(16'hFF30, d);
    n_checks++; if (d !== 32'h020) begin $display("FAIL rstmid_status got=%h exp=020", d); n_fail++; end
    ahb_read(16'hFF34, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL rstmid_ctrl got=%h exp=0", d); n_fail++; end
    ahb_read(16'hFF20, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL rstmid_dl got=%h exp=0", d); n_fail++; end
`ifdef CAN_RX_FILTER_EN
    ahb_read(16'hFF38, d);
    n_checks++; if (d !== 32'h0) begin $display("FAIL rstmid_filt_id got=%h exp=0", d); n_fail++; end
`endif
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; rx_data = '0; rx_len = '0;
    rx_fmt = 1'b0; rx_type = '0; rx_id = '0;
    idle_bus(); bus.HADDR = '0; bus.HWDATA = '0; bus.HSIZE = 3'b010; bus.HBURST = 3'b000;
    test_reset();
    test_basic();
    test_overflow();
    test_pop_push_full();
    test_irq();
    test_check_overflow();
    test_unmapped();
`ifdef CAN_RX_FILTER_EN
    test_filter();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
